// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sipo_pkg;

  // Controller state: IDLE waits for frame_start, SHIFT collects a word.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_e;

  localparam int SIPO_DEFAULT_WIDTH = 4;

endpackage : sipo_pkg

// File: rtl/sipo_shreg.sv
// WIDTH-bit left-shifting register; the first bit shifted in ends up in the MSB.
// Latency: 1 cycle from en/din to q.
// Backpressure: none; holds its contents while en is low.
//
// Ports: clk, reset (sync, active-high), en (shift this cycle), din (serial bit),
//        q (register contents).
module sipo_shreg #(
  parameter int WIDTH = sipo_pkg::SIPO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule : sipo_shreg

// File: rtl/sipo_frame_ctrl.sv
// Sequences a SIPO shift datapath: qualifies bits, counts them, and buffers each finished word.
// Latency: out_valid rises the cycle after the last bit of a word is accepted.
// Backpressure: one-entry buffer; a word completing while the buffer is full and unread is dropped (overrun).
//
// Ports: clk, reset (sync, active-high); ser_in/ser_valid/frame_start (serial input);
//        out_data/out_valid/out_ready (parallel output handshake); busy, bit_cnt (status);
//        overrun, frame_err (sticky error flags), clr_err (clears both flags).
module sipo_frame_ctrl
  import sipo_pkg::*;
#(
  parameter  int WIDTH      = SIPO_DEFAULT_WIDTH,
  parameter  int CONTINUOUS = 0,
  localparam int CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  sipo_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             shift_en;
  logic             word_done;
  logic             ovr_evt;
  logic             ferr_evt;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] word;
  logic             unused_shreg_msb;

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .en    (shift_en),
    .din   (ser_in),
    .q     (shreg_q)
  );

  // The completing bit is still on ser_in, so the word is formed from the
  // lower bits of the register plus that bit; the old MSB falls off.
  assign word             = {shreg_q[WIDTH-2:0], ser_in};
  assign unused_shreg_msb = shreg_q[WIDTH-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    shift_en    = 1'b0;
    word_done   = 1'b0;
    ovr_evt     = 1'b0;
    ferr_evt    = 1'b0;

    if (ser_valid) begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            shift_en = 1'b1;
            cnt_d    = CNT_W'(1);
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          shift_en = 1'b1;
          if (frame_start) begin
            // Resync: drop the partial word, this bit becomes bit 0.
            // Takes priority over completion on the WIDTH-th bit.
            ferr_evt = 1'b1;
            cnt_d    = CNT_W'(1);
          end else if (cnt_q == LAST_IDX) begin
            word_done = 1'b1;
            cnt_d     = '0;
            state_d   = (CONTINUOUS != 0) ? SHIFT : IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // One-entry buffer: a read and a new word on the same edge hand over
    // without a bubble; a full, unread buffer keeps its word.
    if (word_done) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = word;
        out_valid_d = 1'b1;
      end else begin
        ovr_evt = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Sticky flags: a new event beats a simultaneous clear.
    overrun_d   = ovr_evt  | (overrun_q   & ~clr_err);
    frame_err_d = ferr_evt | (frame_err_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == SHIFT);
  assign bit_cnt   = cnt_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule : sipo_frame_ctrl

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: one instance per CONTINUOUS setting, shared stimulus.
// Latency: checks sample #1 after each rising edge.
// Backpressure: out_ready driven directly by the stimulus.
module tb_sipo_frame_ctrl;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ser_in = 1'b0;
  logic ser_valid = 1'b0;
  logic frame_start = 1'b0;
  logic out_ready = 1'b0;
  logic clr_err = 1'b0;

  logic [W-1:0]  out_data0, out_data1;
  logic          out_valid0, out_valid1;
  logic          busy0, busy1;
  logic [CW-1:0] bit_cnt0, bit_cnt1;
  logic          overrun0, overrun1;
  logic          frame_err0, frame_err1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(W), .CONTINUOUS(0)) dut0 (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
    .frame_start(frame_start), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .busy(busy0), .bit_cnt(bit_cnt0),
    .overrun(overrun0), .frame_err(frame_err0), .clr_err(clr_err)
  );

  sipo_frame_ctrl #(.WIDTH(W), .CONTINUOUS(1)) dut1 (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
    .frame_start(frame_start), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .busy(busy1), .bit_cnt(bit_cnt1),
    .overrun(overrun1), .frame_err(frame_err1), .clr_err(clr_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    ser_in      = b;
    ser_valid   = 1'b1;
    frame_start = fs;
    tick();
    ser_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1;
    // Reset state
    do_reset();
    check_eq("rst_data",  32'(out_data0),  32'h0);
    check_eq("rst_valid", 32'(out_valid0), 32'h0);
    check_eq("rst_busy",  32'(busy0),      32'h0);
    check_eq("rst_cnt",   32'(bit_cnt0),   32'h0);
    check_eq("rst_ovr",   32'(overrun0),   32'h0);
    check_eq("rst_ferr",  32'(frame_err0), 32'h0);

    // 1: basic word 1011, CONTINUOUS=0
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    check_eq("t1_busy_b0", 32'(busy0), 32'h1);
    check_eq("t1_cnt_b0",  32'(bit_cnt0), 32'h1);
    send_bit(1'b0, 1'b0);
    check_eq("t1_cnt_b1",  32'(bit_cnt0), 32'h2);
    send_bit(1'b1, 1'b0);
    check_eq("t1_cnt_b2",  32'(bit_cnt0), 32'h3);
    check_eq("t1_vld_b2",  32'(out_valid0), 32'h0);
    send_bit(1'b1, 1'b0);
    check_eq("t1_vld",  32'(out_valid0), 32'h1);
    check_eq("t1_data", 32'(out_data0),  32'hB);
    check_eq("t1_busy", 32'(busy0),      32'h0);
    check_eq("t1_cnt",  32'(bit_cnt0),   32'h0);
    tick();
    check_eq("t1_vld_drop", 32'(out_valid0), 32'h0);
    check_eq("t1_data_hold", 32'(out_data0), 32'hB);
    send_bit(1'b1, 1'b0);
    check_eq("t1_idle_ignore", 32'(busy0), 32'h0);

    // 2: gap of two cycles between bits 2 and 3
    do_reset();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("t2_gap_cnt", 32'(bit_cnt0), 32'h2);
      check_eq("t2_gap_vld", 32'(out_valid0), 32'h0);
    end
    send_bit(1'b1, 1'b0);
    check_eq("t2_vld_early", 32'(out_valid0), 32'h0);
    send_bit(1'b1, 1'b0);
    check_eq("t2_vld",  32'(out_valid0), 32'h1);
    check_eq("t2_data", 32'(out_data0),  32'hB);

    // 3: overrun on CONTINUOUS=1 instance
    do_reset();
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_eq("t3_vld1",  32'(out_valid1), 32'h1);
    check_eq("t3_data1", 32'(out_data1),  32'hB);
    check_eq("t3_busy",  32'(busy1),      32'h1);
    check_eq("t3_cnt",   32'(bit_cnt1),   32'h0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_eq("t3_data_hold", 32'(out_data1), 32'hB);
    check_eq("t3_ovr_pre",   32'(overrun1),  32'h0);
    send_bit(1'b0, 1'b0);
    check_eq("t3_data_kept", 32'(out_data1), 32'hB);
    check_eq("t3_ovr",       32'(overrun1),  32'h1);
    check_eq("t3_vld_kept",  32'(out_valid1), 32'h1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("t3_vld_drop", 32'(out_valid1), 32'h0);
    check_eq("t3_ovr_sticky", 32'(overrun1), 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_eq("t3_ovr_clr", 32'(overrun1), 32'h0);

    // 4: read and completion on the same edge
    do_reset();
    out_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    check_eq("t4_vld",  32'(out_valid1), 32'h1);
    check_eq("t4_data", 32'(out_data1),  32'h6);
    check_eq("t4_ovr",  32'(overrun1),   32'h0);
    tick();
    check_eq("t4_vld_drop", 32'(out_valid1), 32'h0);

    // 5: resync mid-word
    do_reset();
    out_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check_eq("t5_ferr",  32'(frame_err0), 32'h1);
    check_eq("t5_cnt",   32'(bit_cnt0),   32'h1);
    check_eq("t5_busy",  32'(busy0),      32'h1);
    check_eq("t5_novld", 32'(out_valid0), 32'h0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check_eq("t5_novld2", 32'(out_valid0), 32'h0);
    send_bit(1'b0, 1'b0);
    check_eq("t5_vld",  32'(out_valid0), 32'h1);
    check_eq("t5_data", 32'(out_data0),  32'h2);
    // frame_start on what would be the 4th bit: resync, no word
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    check_eq("t5_b4_novld", 32'(out_valid0), 32'h0);
    check_eq("t5_b4_cnt",   32'(bit_cnt0),   32'h1);
    // clear and a new framing error together: set wins
    send_bit(1'b1, 1'b0);
    clr_err = 1'b1;
    send_bit(1'b0, 1'b1);
    clr_err = 1'b0;
    check_eq("t5_setwins", 32'(frame_err0), 32'h1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check_eq("t5_ferr_clr", 32'(frame_err0), 32'h0);

    // 6: reset mid-word with a buffered word still present (0010 from test 5)
    check_eq("t6_pre_data", 32'(out_data0), 32'h2);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    do_reset();
    check_eq("t6_data", 32'(out_data0),  32'h0);
    check_eq("t6_vld",  32'(out_valid0), 32'h0);
    check_eq("t6_busy", 32'(busy0),      32'h0);
    check_eq("t6_cnt",  32'(bit_cnt0),   32'h0);
    check_eq("t6_ferr", 32'(frame_err0), 32'h0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check_eq("t6_ign_busy", 32'(busy0),    32'h0);
    check_eq("t6_ign_cnt",  32'(bit_cnt0), 32'h0);
    send_bit(1'b1, 1'b1);
    check_eq("t6_start_busy", 32'(busy0),    32'h1);
    check_eq("t6_start_cnt",  32'(bit_cnt0), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sipo_frame_ctrl
